// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-stage access controller.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned-access trap).
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    // Byte-lane geometry of the 32-bit little-endian data word.
    localparam int LANE_BITS = 8;
    localparam int NUM_LANES = 4;

    // The reserved size encoding 2'b11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    // True when the low address bits do not match the natural alignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic result;
        if (size[1]) begin
            result = (addr_lo != 2'b00);
        end else if (size == SIZE_HALF) begin
            result = addr_lo[0];
        end else begin
            result = 1'b0;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response and memory-side bus of the access controller.
// Optional feature macro: MEM_MISALIGN_TRAP_EN adds the Exc flag.
interface mem_access_ctrl_if;
    // EX/MEM request
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [1:0]  Size_i;
    logic        Unsigned_i;
    logic [31:0] Addr_i;
    logic [31:0] Wd_i;
    // Pipeline response
    logic        Stall;
    logic [31:0] LoadData;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        Exc;
`endif
    // Data memory port
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] Wd;
    logic [31:0] Rd;

`ifdef MEM_MISALIGN_TRAP_EN
    // Controller view
    modport slave (
        input  MemRead_i, MemWrite_i, Size_i, Unsigned_i, Addr_i, Wd_i, Rd,
        output Stall, LoadData, Exc, MemRead, MemWrite, Addr, Wd
    );
    // Pipeline + memory view
    modport master (
        output MemRead_i, MemWrite_i, Size_i, Unsigned_i, Addr_i, Wd_i, Rd,
        input  Stall, LoadData, Exc, MemRead, MemWrite, Addr, Wd
    );
`else
    // Controller view
    modport slave (
        input  MemRead_i, MemWrite_i, Size_i, Unsigned_i, Addr_i, Wd_i, Rd,
        output Stall, LoadData, MemRead, MemWrite, Addr, Wd
    );
    // Pipeline + memory view
    modport master (
        output MemRead_i, MemWrite_i, Size_i, Unsigned_i, Addr_i, Wd_i, Rd,
        input  Stall, LoadData, MemRead, MemWrite, Addr, Wd
    );
`endif

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extraction/extension and store-lane merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rd_i,
    input  logic [31:0] wd_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [31:0] byte_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_shift = rd_i >> {lane_i, 3'b000};
    assign byte_sel   = byte_shift[7:0];
    assign half_sel   = lane_i[1] ? rd_i[31:16] : rd_i[15:0];

    // Pick the addressed lane and sign- or zero-extend it.
    always_comb begin
        load_data_o = rd_i;
        if (size_i == SIZE_BYTE) begin
            load_data_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (size_i == SIZE_HALF) begin
            load_data_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end
    end

    // Each byte lane takes store data when it is targeted, otherwise keeps the old memory byte.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] lane_src;

            assign lane_hit = is_word(size_i)     ? 1'b1 :
                              (size_i == SIZE_HALF) ? (lane_i[1] == LANE[1]) :
                                                      (lane_i == LANE);
            assign lane_src = is_word(size_i)     ? wd_i[gi*LANE_BITS +: LANE_BITS] :
                              (size_i == SIZE_HALF) ? (LANE[0] ? wd_i[15:8] : wd_i[7:0]) :
                                                      wd_i[7:0];
            assign merged_o[gi*LANE_BITS +: LANE_BITS] =
                lane_hit ? lane_src : rd_i[gi*LANE_BITS +: LANE_BITS];
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: loads, word stores, and two-cycle
// read-modify-write for byte/halfword stores into a word-only memory.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (flag misaligned accesses on Exc).
module mem_access_ctrl
    import mem_access_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst_n,
    mem_access_ctrl_if.slave   bus
);

    state_t      state_q, state_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] addr_q, addr_d;

    logic [31:0] aligned_addr;
    logic        store_req;
    logic        trap;
    logic        sub_store;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    assign aligned_addr = {bus.Addr_i[31:2], 2'b00};
    // A store always wins over a simultaneous load.
    assign store_req    = bus.MemWrite_i;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (bus.MemRead_i | bus.MemWrite_i) & misaligned(bus.Size_i, bus.Addr_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign sub_store = store_req & ~is_word(bus.Size_i) & ~trap;

    mem_lane_align u_lane_align (
        .size_i      (bus.Size_i),
        .unsigned_i  (bus.Unsigned_i),
        .lane_i      (bus.Addr_i[1:0]),
        .rd_i        (bus.Rd),
        .wd_i        (bus.Wd_i),
        .load_data_o (lane_load),
        .merged_o    (lane_merged)
    );

    // State register plus the merged word and address held across the RMW cycle.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            merged_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            merged_q <= merged_d;
            addr_q   <= addr_d;
        end
    end

    // Next state: a sub-word store captures the merged word and moves to the write cycle.
    always_comb begin
        state_d  = state_q;
        merged_d = merged_q;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (sub_store) begin
                    state_d  = RMW_WR;
                    merged_d = lane_merged;
                    addr_d   = aligned_addr;
                end
            end
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: everything held at zero during reset so no write can leak out.
    always_comb begin
        bus.Stall    = 1'b0;
        bus.LoadData = '0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Addr     = '0;
        bus.Wd       = '0;
`ifdef MEM_MISALIGN_TRAP_EN
        bus.Exc      = 1'b0;
`endif
        if (Rst_n) begin
            case (state_q)
                IDLE: begin
                    bus.Addr = aligned_addr;
                    if (trap) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        bus.Exc = 1'b1;
`endif
                    end else if (store_req) begin
                        if (sub_store) begin
                            bus.MemRead = 1'b1;
                            bus.Stall   = 1'b1;
                        end else begin
                            bus.MemWrite = 1'b1;
                            bus.Wd       = bus.Wd_i;
                        end
                    end else if (bus.MemRead_i) begin
                        bus.MemRead  = 1'b1;
                        bus.LoadData = lane_load;
                    end
                end
                RMW_WR: begin
                    bus.MemWrite = 1'b1;
                    bus.Wd       = merged_q;
                    bus.Addr     = addr_q;
                end
                default: ;
            endcase
        end
    end

endmodule
